scoreboard_hazard: RTL

- Parametrised successor to the pipeline hazard unit of the 5-stage MIPS datapath.
- Replaces fixed writereg-compare stall equations with a per-register pending-write scoreboard that counts down producer latency, so load latency is configurable.
- Adds a registered precise-exception latch: an exception raised while the pipeline is frozen by a cache stall is held, then flushed the first unfrozen cycle, never dropped and never flushed mid-freeze.
- Drives stall/flush for F/D/E/M/W and the exception redirect PC.

---
 rtl/hazard_pkg.sv | 11 +
 rtl/scoreboard_hazard_if.sv | 54 +++++
 rtl/reg_scoreboard.sv | 39 +++
 rtl/scoreboard_hazard.sv | 125 ++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the scoreboard hazard unit.
package hazard_pkg;

    localparam logic [31:0] ERET_CODE   = 32'h0000000E;
    localparam logic [31:0] EXC_VEC_DEF = 32'hBFC00380;

    function automatic int cnt_width(input int load_lat);
        return $clog2(load_lat + 1);
    endfunction

endpackage

// File: rtl/scoreboard_hazard_if.sv
// Pipeline-side signal bundle of the hazard unit.
interface scoreboard_hazard_if #(
    parameter int AW = 5
);
    logic          d_stall;
    logic          i_stall;
    logic          div_busy;
    logic          issue_d;
    logic [AW-1:0] rs_d;
    logic [AW-1:0] rt_d;
    logic          use_rs_d;
    logic          use_rt_d;
    logic          early_d;
    logic [AW-1:0] wreg_d;
    logic          regwrite_d;
    logic          is_load_d;
    logic [31:0]   except_type_m;
    logic [31:0]   epc_m;

    logic          stall_f;
    logic          stall_d;
    logic          stall_e;
    logic          stall_m;
    logic          stall_w;
    logic          flush_f;
    logic          flush_d;
    logic          flush_e;
    logic          flush_m;
    logic          flush_w;
    logic [31:0]   newpc;
    logic          exc_taken;
    logic          longest_stall;

    modport master (
        output d_stall, i_stall, div_busy, issue_d,
        output rs_d, rt_d, use_rs_d, use_rt_d, early_d,
        output wreg_d, regwrite_d, is_load_d,
        output except_type_m, epc_m,
        input  stall_f, stall_d, stall_e, stall_m, stall_w,
        input  flush_f, flush_d, flush_e, flush_m, flush_w,
        input  newpc, exc_taken, longest_stall
    );

    modport slave (
        input  d_stall, i_stall, div_busy, issue_d,
        input  rs_d, rt_d, use_rs_d, use_rt_d, early_d,
        input  wreg_d, regwrite_d, is_load_d,
        input  except_type_m, epc_m,
        output stall_f, stall_d, stall_e, stall_m, stall_w,
        output flush_f, flush_d, flush_e, flush_m, flush_w,
        output newpc, exc_taken, longest_stall
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write countdown array; entry 0 is always zero.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_idx,
    input  logic [CNT_W-1:0] wr_val,
    input  logic             dec_en,
    input  logic             clr,
    input  logic [AW-1:0]    rd_idx_a,
    output logic [CNT_W-1:0] cnt_a,
    input  logic [AW-1:0]    rd_idx_b,
    output logic [CNT_W-1:0] cnt_b
);

    logic [CNT_W-1:0] cnt [NREG];

    // A new issue to a register overrides its decrement in the same cycle.
    always_ff @(posedge clk) begin
        cnt[0] <= '0;
        for (int r = 1; r < NREG; r++) begin
            if (rst || clr) begin
                cnt[r] <= '0;
            end else if (wr_en && (int'(wr_idx) == r)) begin
                cnt[r] <= wr_val;
            end else if (dec_en && (cnt[r] != '0)) begin
                cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

    assign cnt_a = cnt[rd_idx_a];
    assign cnt_b = cnt[rd_idx_b];

endmodule

// File: rtl/scoreboard_hazard.sv
// Scoreboard-based stall/flush control with a precise-exception latch.
module scoreboard_hazard
    import hazard_pkg::*;
#(
    parameter int          NREG     = 32,
    parameter int          AW       = 5,
    parameter int          ALU_LAT  = 1,
    parameter int          LOAD_LAT = 2,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input logic                clk,
    input logic                rst,
    scoreboard_hazard_if.slave bus
);

    localparam int CNT_W = cnt_width(LOAD_LAT);

    logic             freeze;
    logic             exc_live;
    logic             exc_go;
    logic             dep_stall;
    logic             hit_rs;
    logic             hit_rt;
    logic             fire;
    logic             stall_fd;
    logic             stall_ew;
    logic [CNT_W-1:0] cnt_rs;
    logic [CNT_W-1:0] cnt_rt;
    logic [CNT_W-1:0] wr_val;
    logic             wr_en;

    logic             pend_v;
    logic [31:0]      pend_type;
    logic [31:0]      pend_epc;
    logic [31:0]      sel_type;
    logic [31:0]      sel_epc;

    assign freeze   = bus.d_stall | bus.i_stall | bus.div_busy;
    assign exc_live = bus.except_type_m != '0;
    assign exc_go   = ~freeze & (pend_v | exc_live);

    // Early consumers need the value now; others can take it via E forwarding.
    assign hit_rs = bus.use_rs_d &
        (bus.early_d ? (cnt_rs != '0) : (cnt_rs > CNT_W'(ALU_LAT)));
    assign hit_rt = bus.use_rt_d &
        (bus.early_d ? (cnt_rt != '0) : (cnt_rt > CNT_W'(ALU_LAT)));
    assign dep_stall = bus.issue_d & (hit_rs | hit_rt);

    assign stall_fd = freeze | dep_stall | pend_v;
    assign stall_ew = freeze | pend_v;

    assign fire   = bus.issue_d & ~stall_fd & ~exc_go;
    assign wr_en  = fire & bus.regwrite_d & (bus.wreg_d != '0);
    assign wr_val = bus.is_load_d ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);

    reg_scoreboard #(
        .NREG  (NREG),
        .AW    (AW),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_idx   (bus.wreg_d),
        .wr_val   (wr_val),
        .dec_en   (~freeze),
        .clr      (exc_go),
        .rd_idx_a (bus.rs_d),
        .cnt_a    (cnt_rs),
        .rd_idx_b (bus.rt_d),
        .cnt_b    (cnt_rt)
    );

    // Hold the first exception seen during a freeze until it can be flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v    <= 1'b0;
            pend_type <= '0;
            pend_epc  <= '0;
        end else if (exc_go) begin
            pend_v <= 1'b0;
        end else if (exc_live && freeze && !pend_v) begin
            pend_v    <= 1'b1;
            pend_type <= bus.except_type_m;
            pend_epc  <= bus.epc_m;
        end
    end

    assign sel_type = pend_v ? pend_type : bus.except_type_m;
    assign sel_epc  = pend_v ? pend_epc  : bus.epc_m;

    always_comb begin
        bus.stall_f   = 1'b0;
        bus.stall_d   = 1'b0;
        bus.stall_e   = 1'b0;
        bus.stall_m   = 1'b0;
        bus.stall_w   = 1'b0;
        bus.flush_f   = 1'b1;
        bus.flush_d   = 1'b1;
        bus.flush_e   = 1'b1;
        bus.flush_m   = 1'b1;
        bus.flush_w   = 1'b1;
        bus.exc_taken = 1'b0;
        bus.newpc     = '0;
        if (!rst) begin
            bus.stall_f   = stall_fd & ~exc_go;
            bus.stall_d   = stall_fd & ~exc_go;
            bus.stall_e   = stall_ew & ~exc_go;
            bus.stall_m   = stall_ew & ~exc_go;
            bus.stall_w   = stall_ew & ~exc_go;
            bus.flush_f   = exc_go;
            bus.flush_d   = exc_go;
            bus.flush_e   = exc_go | (dep_stall & ~freeze);
            bus.flush_m   = exc_go;
            bus.flush_w   = exc_go;
            bus.exc_taken = exc_go;
            if (exc_go) begin
                bus.newpc = (sel_type == ERET_CODE) ? sel_epc : EXC_VEC;
            end
        end
        bus.longest_stall = bus.stall_f | bus.stall_d | bus.stall_e |
                            bus.stall_m | bus.stall_w;
    end

endmodule
